// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared constants and sizing helpers for the switch debouncer
package switch_pkg;

  localparam int N_SWITCHES          = 6;
  localparam int CLK_HZ_DEFAULT      = 50_000_000;
  localparam int DEBOUNCE_US_DEFAULT = 10_000;

  // Number of clocks a synchronised level must hold before it is accepted
  function automatic int stable_cycles(input int clk_hz, input int debounce_us);
    return (clk_hz / 1_000_000) * debounce_us;
  endfunction

  // Counter width able to hold 0..STABLE_CYCLES
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - one switch: two-flop synchroniser, stability counter, edge pulses
module debounce_cell #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

  // Two-flop synchroniser; raw is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Stability counter: any return to the stable level clears it; terminal compare precedes increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (cnt == TERMINAL) begin
        stable <= sync_b;
        cnt    <= '0;
        rise   <= sync_b;
        fall   <= ~sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - debounced slide-switch bank with rise/fall pulses and change strobe
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int N           = N_SWITCHES,
  parameter int CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int DEBOUNCE_US = DEBOUNCE_US_DEFAULT
) (
  input  logic         CLOCK_50,
  input  logic         KEY0,
  input  logic [0:N-1] SW,
  output logic [0:N-1] SW_STABLE,
  output logic [0:N-1] SW_RISE,
  output logic [0:N-1] SW_FALL,
  output logic         SW_CHANGED
);

  localparam int STABLE_CYCLES = stable_cycles(CLK_HZ, DEBOUNCE_US);
  localparam int CNT_W         = cnt_width(STABLE_CYCLES);

  // A one-cycle window cannot distinguish a level from a glitch
  if (STABLE_CYCLES < 2) begin : g_bad_config
    $error("switch_debouncer: STABLE_CYCLES must be at least 2");
  end

  // One independent debounce cell per switch
  for (genvar i = 0; i < N; i++) begin : g_cell
    debounce_cell #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_cell (
      .clk   (CLOCK_50),
      .rst_n (KEY0),
      .raw   (SW[i]),
      .stable(SW_STABLE[i]),
      .rise  (SW_RISE[i]),
      .fall  (SW_FALL[i])
    );
  end

  // Bank strobe is a plain OR of flop outputs, so it coincides with the per-bit pulses
  assign SW_CHANGED = (|SW_RISE) | (|SW_FALL);

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed self-checking bench for switch_debouncer
module tb_switch_debouncer;

  localparam int N = 6;

  logic         CLOCK_50;
  logic         KEY0;
  logic [0:N-1] SW;
  logic [0:N-1] SW_STABLE;
  logic [0:N-1] SW_RISE;
  logic [0:N-1] SW_FALL;
  logic         SW_CHANGED;

  int checks;
  int errors;

  switch_debouncer #(
    .N          (N),
    .CLK_HZ     (1_000_000),
    .DEBOUNCE_US(8)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY0      (KEY0),
    .SW        (SW),
    .SW_STABLE (SW_STABLE),
    .SW_RISE   (SW_RISE),
    .SW_FALL   (SW_FALL),
    .SW_CHANGED(SW_CHANGED)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance one clock and settle away from the edge
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [0:N-1] st, input logic [0:N-1] ri,
                         input logic [0:N-1] fa, input logic ch);
    chk({tag, ".stable"}, 32'(SW_STABLE), 32'(st));
    chk({tag, ".rise"}, 32'(SW_RISE), 32'(ri));
    chk({tag, ".fall"}, 32'(SW_FALL), 32'(fa));
    chk({tag, ".changed"}, 32'(SW_CHANGED), 32'(ch));
  endtask

  logic [0:N-1] e;
  logic [0:N-1] st;
  int rise0, fall0, rise0_at, changes;

  initial begin
    checks = 0;
    errors = 0;
    KEY0   = 1'b0;
    SW     = '0;

    // Reset state
    steps(3);
    chk_all("reset", '0, '0, '0, 1'b0);
    KEY0 = 1'b1;
    steps(3);
    chk_all("idle", '0, '0, '0, 1'b0);

    // Clean edge on SW[2]: accepted on the 10th clock only
    SW[2] = 1'b1;
    steps(9);
    chk_all("clean.c9", '0, '0, '0, 1'b0);
    step();
    e = '0; e[2] = 1'b1;
    chk_all("clean.c10", e, e, '0, 1'b1);
    step();
    chk_all("clean.c11", e, '0, '0, 1'b0);
    st = e;

    // Bounce on SW[0]: 1,0,1,0 every 3 cycles then settle at 1
    rise0 = 0; fall0 = 0; rise0_at = -1;
    for (int b = 0; b < 4; b++) begin
      SW[0] = (b % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        step();
        rise0 += int'(SW_RISE[0]);
        fall0 += int'(SW_FALL[0]);
      end
    end
    SW[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (SW_RISE[0]) rise0_at = k;
      rise0 += int'(SW_RISE[0]);
      fall0 += int'(SW_FALL[0]);
    end
    chk("bounce.rise_count", 32'(rise0), 32'd1);
    chk("bounce.rise_cycle", 32'(rise0_at), 32'd10);
    chk("bounce.fall_count", 32'(fall0), 32'd0);
    st[0] = 1'b1;
    chk("bounce.stable", 32'(SW_STABLE), 32'(st));

    // Glitch on SW[5]: 7 cycles high is one short of acceptance
    changes = 0;
    SW[5] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      changes += int'(SW_CHANGED);
    end
    SW[5] = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      changes += int'(SW_CHANGED);
    end
    chk("glitch.changes", 32'(changes), 32'd0);
    chk("glitch.stable", 32'(SW_STABLE), 32'(st));

    // Bring SW[4] to a stable 1
    SW[4] = 1'b1;
    steps(12);
    st[4] = 1'b1;
    chk("pre_sim.stable", 32'(SW_STABLE), 32'(st));

    // Simultaneous SW[1] rise and SW[4] fall
    SW[1] = 1'b1;
    SW[4] = 1'b0;
    steps(9);
    chk_all("sim.c9", st, '0, '0, 1'b0);
    step();
    st[1] = 1'b1; st[4] = 1'b0;
    e = '0; e[1] = 1'b1;
    chk_all("sim.c10", st, e, 6'b000010, 1'b1);
    step();
    chk_all("sim.c11", st, '0, '0, 1'b0);

    // Reset mid-count on SW[3]: count reaches 5 after 7 clocks
    SW[3] = 1'b1;
    steps(7);
    chk("midcnt.pre_stable", 32'(SW_STABLE), 32'(st));
    #2;
    KEY0 = 1'b0;
    #1;
    chk_all("midcnt.async_reset", '0, '0, '0, 1'b0);
    steps(2);
    KEY0 = 1'b1;
    // SW = bits 0..3 high; all four rise together after full latency
    steps(9);
    chk_all("midcnt.c9", '0, '0, '0, 1'b0);
    step();
    chk_all("midcnt.c10", 6'b111100, 6'b111100, '0, 1'b1);
    step();
    chk("midcnt.c11_changed", 32'(SW_CHANGED), 32'd0);

    // Power-up with every switch high
    KEY0 = 1'b0;
    SW   = '1;
    steps(3);
    chk_all("pwr.reset", '0, '0, '0, 1'b0);
    KEY0 = 1'b1;
    steps(9);
    chk_all("pwr.c9", '0, '0, '0, 1'b0);
    step();
    chk_all("pwr.c10", '1, '1, '0, 1'b1);
    step();
    chk_all("pwr.c11", '1, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronises and debounces the slide-switch bank before it reaches the switch-to-LED/7-segment display stage, which consumes its stable levels. Each switch passes through a two-flop synchroniser and a per-switch stability counter. The block emits a clean level per switch, one-cycle rise/fall pulses, and a bank-wide change strobe. The display stage then sees exactly one transition per physical switch flip.

## Interface
- N, default 6: number of switches; all vectors are declared [0:N-1], bit i tracks SW[i].
- CLK_HZ, default 50_000_000: clock frequency in Hz.
- DEBOUNCE_US, default 10_000: required stable time in microseconds.
- Derived constant STABLE_CYCLES = CLK_HZ/1_000_000 * DEBOUNCE_US; must be ≥ 2 (elaboration error otherwise).

- CLOCK_50  input  1  system clock, rising edge.
- KEY0  input  1  reset, asynchronous, active-low.
- SW  input  [0:N-1]  raw switch levels, asynchronous to CLOCK_50, may bounce.
- SW_STABLE  output  [0:N-1]  debounced level per switch.
- SW_RISE  output  [0:N-1]  one-cycle pulse when SW_STABLE[i] goes 0→1.
- SW_FALL  output  [0:N-1]  one-cycle pulse when SW_STABLE[i] goes 1→0.
- SW_CHANGED  output  1  one-cycle pulse, OR of all SW_RISE and SW_FALL bits.

## Operation
- Per switch i, independent of all others:
  - two-flop synchroniser produces s[i];
  - counter cnt[i], width $clog2(STABLE_CYCLES+1), unsigned.
- Each clock:
  - if s[i] == SW_STABLE[i]: cnt[i] ← 0;
  - else if cnt[i] == STABLE_CYCLES-1: SW_STABLE[i] ← s[i], cnt[i] ← 0, and assert the matching RISE/FALL bit for that cycle;
  - else cnt[i] ← cnt[i]+1.
- Any bounce back to the current stable value before terminal count resets cnt[i] to 0. There is no partial credit.
- Counter never wraps: terminal compare precedes increment.
- Per bit, RISE[i] and FALL[i] are mutually exclusive. Several bits may pulse in the same cycle, and SW_CHANGED is a single pulse in that case.
- Reset (KEY0 low, any time including mid-count):
  - synchroniser flops, cnt, SW_STABLE, SW_RISE, SW_FALL and SW_CHANGED all → 0 immediately;
  - pending counts are discarded.
- After reset release, a switch already up is treated as a normal 0→1 change. It produces SW_RISE after the full latency.

## Timing
- Latency from a clean SW edge to SW_STABLE change: 2 cycles of synchroniser plus STABLE_CYCLES cycles of counting.
- SW_RISE, SW_FALL and SW_CHANGED are registered. They assert in the same cycle SW_STABLE updates and last exactly one cycle.
- A pulse shorter than STABLE_CYCLES synchronised cycles never reaches SW_STABLE.
- Minimum spacing between two accepted transitions on one switch is STABLE_CYCLES cycles.
- All outputs are registered; there is no combinational path from SW to any output.

## Structure
- Shared package switch_pkg holds:
  - N_SWITCHES = 6;
  - the CLK_HZ default;
  - the DEBOUNCE_US default;
  - a function computing STABLE_CYCLES and its counter width.
- Sub-module debounce_cell contains one switch's synchroniser, counter and edge-pulse logic; ports are clock, reset, raw bit, stable, rise and fall.
- switch_debouncer instantiates N debounce_cell via generate and ORs the pulses into SW_CHANGED.

## Test plan
Bench parameters: N=6, CLK_HZ=1_000_000, DEBOUNCE_US=8, so STABLE_CYCLES=8.
- Clean edge: SW[2] 0→1 at cycle 0 → SW_STABLE[2]=1 and SW_RISE[2]=SW_CHANGED=1 at cycle 10 only; other bits stay 0.
- Bounce rejection: SW[0] toggles 1,0,1,0 with 3-cycle spacing, then settles at 1 → exactly one SW_RISE[0], 10 cycles after the final edge; no SW_FALL[0].
- Glitch: SW[5] high for 7 cycles then low → SW_STABLE[5] stays 0, and no pulse occurs.
- Simultaneous: SW[1] 0→1 and SW[4] 1→0 (stable at 1 beforehand) in the same cycle → SW_RISE[1] and SW_FALL[4] in the same cycle, with SW_CHANGED high for one cycle only.
- Reset mid-count: SW[3] goes high, then KEY0 is pulled low at count 5 → all outputs 0 at once. On release with SW[3] still high, SW_RISE[3] fires 10 cycles after release.
- Power-up with all switches high → after reset release, SW_STABLE=6'b111111 at cycle 10, all six SW_RISE bits pulse together, and a single SW_CHANGED.
